imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the decode stage. Supports all RV32/RV64

---
 rtl/imm_gen_pipe.sv | 144 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry elastic output buffer (valid/ready on both sides).
// Optional stall counter on perf_stall is enabled by defining IMMGEN_PERF_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
`ifdef IMMGEN_PERF_EN
  ,
  output logic [15:0]      perf_stall
`endif
);

  typedef enum logic [2:0] {
    FMT_I  = 3'b000,
    FMT_S  = 3'b001,
    FMT_B  = 3'b010,
    FMT_J  = 3'b011,
    FMT_U  = 3'b100,
    FMT_Z  = 3'b101,
    FMT_SH = 3'b110,
    FMT_RS = 3'b111
  } fmt_e;

  logic        sgn;
  logic [63:0] imm64;
  logic        dec_illegal;
  logic [XLEN-1:0] dec_imm;

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  assign sgn = in_instr[31];

  // Decode into a 64-bit value so every format is built the same way for both XLEN settings.
  always_comb begin
    imm64       = 64'd0;
    dec_illegal = 1'b0;
    case (fmt_e'(in_immsrc))
      FMT_I:  imm64 = {{52{sgn}}, in_instr[31:20]};
      FMT_S:  imm64 = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:  imm64 = {{51{sgn}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
      FMT_J:  imm64 = {{43{sgn}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
      FMT_U:  imm64 = {{32{sgn}}, in_instr[31:12], 12'b0};
      FMT_Z:  imm64 = {59'd0, in_instr[19:15]};
      FMT_SH: begin
        if (XLEN == 64) imm64 = {58'd0, in_instr[25:20]};
        else            imm64 = {59'd0, in_instr[24:20]};
      end
      FMT_RS: begin
        imm64       = 64'd0;
        dec_illegal = 1'b1;
      end
      default: begin
        imm64       = 64'd0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_imm = imm64[XLEN-1:0];

  logic [XLEN-1:0]  mem_imm [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic             mem_ill [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             ready_en;
  logic             push;
  logic             pop;

  // ready_en holds in_ready low until the first edge after reset is released.
  assign in_ready  = ready_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_imm     = mem_imm[rd_ptr];
  assign out_tag     = mem_tag[rd_ptr];
  assign out_illegal = mem_ill[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_imm[0] <= '0;
      mem_imm[1] <= '0;
      mem_tag[0] <= '0;
      mem_tag[1] <= '0;
      mem_ill[0] <= 1'b0;
      mem_ill[1] <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          mem_imm[wr_ptr] <= dec_imm;
          mem_tag[wr_ptr] <= in_tag;
          mem_ill[wr_ptr] <= dec_illegal;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef IMMGEN_PERF_EN
  // Counts cycles where the head is held by downstream; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall <= 16'd0;
    end else if (out_valid && !out_ready && (perf_stall != 16'hFFFF)) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share all inputs.
// Covers every format, buffer ordering/backpressure, flush, async reset and the optional stall counter.
module tb_imm_gen_pipe;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, in_ready64;
  logic        out_valid32, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic [3:0]  out_tag32, out_tag64;
  logic        out_ill32, out_ill64;
`ifdef IMMGEN_PERF_EN
  logic [15:0] perf32, perf64;
`endif

  int checks;
  int failures;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_ill32)
`ifdef IMMGEN_PERF_EN
    , .perf_stall(perf32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_ill64)
`ifdef IMMGEN_PERF_EN
    , .perf_stall(perf64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] instr, input logic [2:0] src, input logic [3:0] tag);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_immsrc = src;
    in_tag    = tag;
  endtask

  task automatic fill_two(input logic [3:0] t0, input logic [3:0] t1);
    out_ready = 1'b0;
    apply_stimulus(32'hFFF00093, 3'b000, t0);
    tick();
    apply_stimulus(32'h7FF00013, 3'b000, t1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_immsrc = 3'd0;
    in_tag    = 4'd0;
    out_ready = 1'b0;

    vecs[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[3]  = '{32'h80000037, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[4]  = '{32'h03F00013, 3'b110, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vecs[5]  = '{32'hFE112E23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[6]  = '{32'h0080006F, 3'b011, 32'h00000008, 64'h0000000000000008, 1'b0};
    vecs[7]  = '{32'h800F8073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[8]  = '{32'h7FF00013, 3'b000, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[9]  = '{32'h12345037, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[10] = '{32'h02000013, 3'b110, 32'h00000000, 64'h0000000000000020, 1'b0};
    vecs[11] = '{32'hFFDFF06F, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};

    // Reset state, and in_ready held low until the first edge after release.
    tick();
    tick();
    check_output("rst out_valid32", {63'd0, out_valid32}, 64'd0);
    check_output("rst out_valid64", {63'd0, out_valid64}, 64'd0);
    check_output("rst in_ready32", {63'd0, in_ready32}, 64'd0);
    check_output("rst out_imm64", out_imm64, 64'd0);
    check_output("rst out_tag32", {60'd0, out_tag32}, 64'd0);
    check_output("rst out_ill32", {63'd0, out_ill32}, 64'd0);
    #2 reset_n = 1'b1;
    #1;
    check_output("rel in_ready before edge", {63'd0, in_ready32}, 64'd0);
    tick();
    check_output("rel in_ready after edge", {63'd0, in_ready32}, 64'd1);
    check_output("rel in_ready64 after edge", {63'd0, in_ready64}, 64'd1);

    // Streaming table, one vector per cycle with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].instr, vecs[i].src, 4'(i));
      tick();
      check_output($sformatf("vec%0d imm32", i), {32'd0, out_imm32}, {32'd0, vecs[i].exp32});
      check_output($sformatf("vec%0d imm64", i), out_imm64, vecs[i].exp64);
      check_output($sformatf("vec%0d ill", i), {62'd0, out_ill32, out_ill64},
                   {62'd0, vecs[i].ill, vecs[i].ill});
      check_output($sformatf("vec%0d tag", i), {56'd0, out_tag32, out_tag64},
                   {56'd0, 4'(i), 4'(i)});
    end
    in_valid = 1'b0;
    tick();
    check_output("drain out_valid", {63'd0, out_valid32}, 64'd0);

    // Backpressure: tags 1,2 accepted, 3 held, then all three drain in order with no bubbles.
    out_ready = 1'b0;
    apply_stimulus(32'h00100013, 3'b000, 4'd1);
    tick();
    apply_stimulus(32'h00200013, 3'b000, 4'd2);
    tick();
    apply_stimulus(32'h00300013, 3'b000, 4'd3);
    check_output("bp in_ready full", {63'd0, in_ready32}, 64'd0);
    tick();
    tick();
    check_output("bp head held tag", {60'd0, out_tag32}, 64'd1);
    check_output("bp head held imm", out_imm64, 64'd1);
    out_ready = 1'b1;
    tick();
    check_output("bp drain tag2", {60'd0, out_tag32}, 64'd2);
    check_output("bp drain valid2", {63'd0, out_valid32}, 64'd1);
    tick();
    in_valid = 1'b0;
    check_output("bp drain tag3", {60'd0, out_tag64}, 64'd3);
    check_output("bp drain imm3", out_imm64, 64'd3);
    tick();
    check_output("bp empty", {63'd0, out_valid64}, 64'd0);

    // Flush at count=2 with in_valid high.
    fill_two(4'd5, 4'd6);
    check_output("fl full before", {63'd0, out_valid32}, 64'd1);
    flush = 1'b1;
    apply_stimulus(32'h00500013, 3'b000, 4'd7);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_output("fl out_valid", {63'd0, out_valid32}, 64'd0);
    check_output("fl in_ready", {63'd0, in_ready32}, 64'd1);
    tick();
    check_output("fl still empty", {63'd0, out_valid64}, 64'd0);

    // Flush at count=1 with an accepted push: the push must still be dropped.
    apply_stimulus(32'h00900013, 3'b000, 4'd9);
    tick();
    flush = 1'b1;
    apply_stimulus(32'h00A00013, 3'b000, 4'd10);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_output("fl1 push dropped", {63'd0, out_valid32}, 64'd0);

    // Async reset mid-stream with one entry buffered.
    apply_stimulus(32'h00B00013, 3'b000, 4'd11);
    tick();
    in_valid = 1'b0;
    check_output("ar valid before", {63'd0, out_valid32}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_output("ar valid async", {62'd0, out_valid32, out_valid64}, 64'd0);
    check_output("ar imm async", out_imm64, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_output("ar no stale entry", {63'd0, out_valid32}, 64'd0);

`ifdef IMMGEN_PERF_EN
    // Stall counter: one entry held for 10 edges, then long enough to saturate.
    reset_n = 1'b0;
    #1;
    check_output("perf reset", {32'd0, perf32, perf64}, 64'd0);
    reset_n = 1'b1;
    tick();
    out_ready = 1'b0;
    apply_stimulus(32'h00C00013, 3'b000, 4'd12);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check_output("perf 10", {48'd0, perf32}, 64'd10);
    for (int c = 0; c < 70000; c++) @(posedge clk);
    #1;
    check_output("perf sat", {32'd0, perf32, perf64}, {32'd0, 16'hFFFF, 16'hFFFF});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
